// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM/WB back-end.
// ALU op codes, the zero-register mask and stage control bundles.
package pipe_pkg;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ORR  = 3'b101;
  localparam logic [2:0] ALU_EOR  = 3'b110;

  // XZR is the all-ones register number, sliced to the address width
  localparam logic [31:0] XZR_MASK = '1;

  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic [2:0] aluctl;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       flagset;
  } idex_ctrl_t;

  typedef struct packed {
    logic valid;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } exmem_ctrl_t;

  typedef struct packed {
    logic valid;
    logic memtoreg;
    logic regwrite;
  } memwb_ctrl_t;

endpackage

// File: rtl/pipe_alu.sv
// Combinational ALU with N/Z/V/C flags.
// SUB is A + ~B + 1 so carry is the unsigned no-borrow bit.
module pipe_alu
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              negative,
  output logic              zero,
  output logic              overflow,
  output logic              carry_out
);

  logic              is_sub;
  logic              arith;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  always_comb begin
    is_sub = (op == ALU_SUB);
    arith  = (op == ALU_ADD) || is_sub;
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff}
           + {{DATA_W{1'b0}}, is_sub};
    case (op)
      ALU_ADD, ALU_SUB: result = sum[DATA_W-1:0];
      ALU_AND:          result = a & b;
      ALU_ORR:          result = a | b;
      ALU_EOR:          result = a ^ b;
      default:          result = b;
    endcase
    negative  = result[DATA_W-1];
    zero      = (result == '0);
    carry_out = arith & sum[DATA_W];
    overflow  = arith
              & (a[DATA_W-1] == b_eff[DATA_W-1])
              & (result[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/pipe_backend.sv
// EX/MEM/WB back-end: pipeline registers, forwarding,
// load-use stall, flush and registered condition flags.
module pipe_backend
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rm,
  input  logic [DATA_W-1:0] id_d1,
  input  logic [DATA_W-1:0] id_d2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [2:0]        id_aluctl,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_flagset,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              negative,
  output logic              zero,
  output logic              overflow,
  output logic              carry_out
);

  localparam logic [REG_AW-1:0] XZR = XZR_MASK[REG_AW-1:0];

  idex_ctrl_t        idex_q, idex_d;
  logic [REG_AW-1:0] idex_rn_q, idex_rn_d;
  logic [REG_AW-1:0] idex_rm_q, idex_rm_d;
  logic [REG_AW-1:0] idex_rd_q, idex_rd_d;
  logic [DATA_W-1:0] idex_d1_q, idex_d1_d;
  logic [DATA_W-1:0] idex_d2_q, idex_d2_d;
  logic [DATA_W-1:0] idex_imm_q, idex_imm_d;

  exmem_ctrl_t       exmem_q, exmem_d;
  logic [REG_AW-1:0] exmem_rd_q, exmem_rd_d;
  logic [DATA_W-1:0] exmem_res_q, exmem_res_d;
  logic [DATA_W-1:0] exmem_st_q, exmem_st_d;

  memwb_ctrl_t       memwb_q, memwb_d;
  logic [REG_AW-1:0] memwb_rd_q, memwb_rd_d;
  logic [DATA_W-1:0] memwb_res_q, memwb_res_d;

  logic [3:0]        flags_q, flags_d;

  logic              em_fwd_ok;
  logic [DATA_W-1:0] op_a, op_b, rm_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_n, alu_z, alu_v, alu_c;

  always_comb begin
    wb_en   = memwb_q.valid & memwb_q.regwrite
            & (memwb_rd_q != XZR);
    wb_addr = memwb_rd_q;
    wb_data = memwb_q.memtoreg ? mem_rdata : memwb_res_q;
  end

  always_comb begin
    stall = idex_q.valid & idex_q.memread
          & (idex_rd_q != XZR) & id_valid
          & ((idex_rd_q == id_rn)
             | (id_use_rm & (idex_rd_q == id_rm)));

    idex_d.valid    = id_valid & ~flush & ~stall;
    idex_d.alusrc   = id_alusrc;
    idex_d.aluctl   = id_aluctl;
    idex_d.memread  = id_memread;
    idex_d.memwrite = id_memwrite;
    idex_d.memtoreg = id_memtoreg;
    idex_d.regwrite = id_regwrite;
    idex_d.flagset  = id_flagset;
    idex_rn_d  = id_rn;
    idex_rm_d  = id_rm;
    idex_rd_d  = id_rd;
    idex_imm_d = id_imm;
    // WB write lands in the same edge, so bypass it here
    idex_d1_d = (wb_en && wb_addr == id_rn) ? wb_data : id_d1;
    idex_d2_d = (wb_en && wb_addr == id_rm) ? wb_data : id_d2;
  end

  always_comb begin
    em_fwd_ok = exmem_q.valid & exmem_q.regwrite
              & ~exmem_q.memread & (exmem_rd_q != XZR);

    if (em_fwd_ok && exmem_rd_q == idex_rn_q)
      op_a = exmem_res_q;
    else if (wb_en && memwb_rd_q == idex_rn_q)
      op_a = wb_data;
    else
      op_a = idex_d1_q;

    if (em_fwd_ok && exmem_rd_q == idex_rm_q)
      rm_val = exmem_res_q;
    else if (wb_en && memwb_rd_q == idex_rm_q)
      rm_val = wb_data;
    else
      rm_val = idex_d2_q;

    op_b = idex_q.alusrc ? idex_imm_q : rm_val;
  end

  pipe_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (idex_q.aluctl),
    .a         (op_a),
    .b         (op_b),
    .result    (alu_res),
    .negative  (alu_n),
    .zero      (alu_z),
    .overflow  (alu_v),
    .carry_out (alu_c)
  );

  always_comb begin
    flags_d = flags_q;
    if (idex_q.valid && idex_q.flagset)
      flags_d = {alu_n, alu_z, alu_v, alu_c};

    exmem_d.valid    = idex_q.valid;
    exmem_d.memread  = idex_q.memread;
    exmem_d.memwrite = idex_q.memwrite;
    exmem_d.memtoreg = idex_q.memtoreg;
    exmem_d.regwrite = idex_q.regwrite;
    exmem_rd_d  = idex_rd_q;
    exmem_res_d = alu_res;
    exmem_st_d  = rm_val;

    memwb_d.valid    = exmem_q.valid;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.regwrite = exmem_q.regwrite & ~exmem_q.memwrite;
    memwb_rd_d  = exmem_rd_q;
    memwb_res_d = exmem_res_q;
  end

  always_comb begin
    mem_addr  = exmem_res_q;
    mem_wdata = exmem_st_q;
    mem_re    = exmem_q.valid & exmem_q.memread;
    mem_we    = exmem_q.valid & exmem_q.memwrite;
    {negative, zero, overflow, carry_out} = flags_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      flags_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    idex_rn_q   <= idex_rn_d;
    idex_rm_q   <= idex_rm_d;
    idex_rd_q   <= idex_rd_d;
    idex_d1_q   <= idex_d1_d;
    idex_d2_q   <= idex_d2_d;
    idex_imm_q  <= idex_imm_d;
    exmem_rd_q  <= exmem_rd_d;
    exmem_res_q <= exmem_res_d;
    exmem_st_q  <= exmem_st_d;
    memwb_rd_q  <= memwb_rd_d;
    memwb_res_q <= memwb_res_d;
  end

endmodule

// File: tb/tb_pipe_backend.sv
// Directed bench for pipe_backend: forwarding, load-use,
// XZR, flush, reset, flags and forward priority.
module tb_pipe_backend;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_use_rm;
  logic [63:0] id_d1, id_d2, id_imm;
  logic        id_alusrc;
  logic [2:0]  id_aluctl;
  logic        id_memread, id_memwrite, id_memtoreg;
  logic        id_regwrite, id_flagset;
  logic        flush;
  logic        stall;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        negative, zero, overflow, carry_out;

  int checks = 0;
  int failures = 0;

  pipe_backend #(.DATA_W(64), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rd(id_rd), .id_use_rm(id_use_rm),
    .id_d1(id_d1), .id_d2(id_d2), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluctl(id_aluctl),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_flagset(id_flagset), .flush(flush), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .negative(negative), .zero(zero),
    .overflow(overflow), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rn = 0; id_rm = 0; id_rd = 0;
    id_use_rm = 0; id_d1 = 0; id_d2 = 0; id_imm = 0;
    id_alusrc = 0; id_aluctl = ALU_PASS;
    id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    id_regwrite = 0; id_flagset = 0; flush = 0;
  endtask

  task automatic op(input logic [4:0] rn, input logic [4:0] rm,
                    input logic [4:0] rd, input logic use_rm,
                    input logic [63:0] d1, input logic [63:0] d2,
                    input logic [63:0] imm, input logic alusrc,
                    input logic [2:0] ctl, input logic mr,
                    input logic mw, input logic m2r,
                    input logic rw, input logic fs);
    id_valid = 1; id_rn = rn; id_rm = rm; id_rd = rd;
    id_use_rm = use_rm; id_d1 = d1; id_d2 = d2; id_imm = imm;
    id_alusrc = alusrc; id_aluctl = ctl;
    id_memread = mr; id_memwrite = mw; id_memtoreg = m2r;
    id_regwrite = rw; id_flagset = fs;
  endtask

  initial begin
    reset = 1; mem_rdata = 0;
    idle();
    step(); step();
    chk("rst_wb_en", wb_en, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_stall", stall, 0);
    chk("rst_flags", {negative, zero, overflow, carry_out}, 0);
    reset = 0;
    step();

    // back-to-back dependents via EX/MEM forwarding
    op(2, 0, 1, 0, 64'd5, 0, 64'd3, 1, ALU_ADD, 0, 0, 0, 1, 0);
    step();
    op(1, 0, 4, 0, 64'd0, 0, 64'd1, 1, ALU_SUB, 0, 0, 0, 1, 0);
    #1 chk("b2b_stall", stall, 0);
    step();
    idle();
    chk("b2b_addr1", mem_addr, 64'd8);
    step();
    chk("b2b_wb1_en", wb_en, 1);
    chk("b2b_wb1_addr", wb_addr, 1);
    chk("b2b_wb1_data", wb_data, 64'd8);
    step();
    chk("b2b_wb2_addr", wb_addr, 4);
    chk("b2b_wb2_data", wb_data, 64'd7);
    step(); step();

    // load-use stall
    op(10, 0, 3, 0, 64'd16, 0, 64'd0, 1, ALU_ADD, 1, 0, 1, 1, 0);
    step();
    op(3, 3, 5, 1, 64'd0, 64'd0, 0, 0, ALU_ADD, 0, 0, 0, 1, 0);
    #1 chk("lu_stall_on", stall, 1);
    step();
    chk("lu_stall_off", stall, 0);
    chk("lu_mem_re", mem_re, 1);
    chk("lu_mem_addr", mem_addr, 64'd16);
    step();
    idle();
    mem_rdata = 64'h55;
    #1;
    chk("lu_wb3_en", wb_en, 1);
    chk("lu_wb3_addr", wb_addr, 3);
    chk("lu_wb3_data", wb_data, 64'h55);
    step();
    chk("lu_bubble_wb", wb_en, 0);
    chk("lu_add_addr", mem_addr, 64'hAA);
    chk("lu_add_re", mem_re, 0);
    step();
    chk("lu_wb5_addr", wb_addr, 5);
    chk("lu_wb5_data", wb_data, 64'hAA);
    mem_rdata = 0;
    step(); step();

    // XZR never written, never forwarded
    op(0, 0, 31, 0, 64'd0, 0, 64'd9, 1, ALU_ADD, 0, 0, 0, 1, 0);
    step();
    op(31, 0, 6, 0, 64'd0, 0, 64'd1, 1, ALU_ADD, 0, 0, 0, 1, 0);
    step();
    idle();
    step();
    chk("xzr_wb_en", wb_en, 0);
    step();
    chk("xzr_wb6_en", wb_en, 1);
    chk("xzr_wb6_addr", wb_addr, 6);
    chk("xzr_wb6_data", wb_data, 64'd1);
    step(); step();

    // flushed store never reaches memory
    op(10, 7, 0, 1, 64'd32, 64'h99, 0, 1, ALU_ADD, 0, 1, 0, 0, 0);
    flush = 1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("flush_mem_we", mem_we, 0);
      step();
    end

    // flags: SUBS 0x7FFF..F - (-1), then ADD without flagset
    op(8, 0, 9, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, '1, 1,
       ALU_SUB, 0, 0, 0, 1, 1);
    step();
    op(8, 0, 10, 0, 64'd1, 0, 64'd1, 1, ALU_ADD, 0, 0, 0, 1, 0);
    step();
    idle();
    chk("flg_n", negative, 1);
    chk("flg_z", zero, 0);
    chk("flg_v", overflow, 1);
    chk("flg_c", carry_out, 0);
    step();
    chk("flg_hold", {negative, zero, overflow, carry_out}, 4'b1010);
    step(); step();

    // forward priority: EX/MEM beats MEM/WB
    op(20, 0, 2, 0, 64'd0, 0, 64'd1, 1, ALU_ADD, 0, 0, 0, 1, 0);
    step();
    op(20, 0, 2, 0, 64'd0, 0, 64'd2, 1, ALU_ADD, 0, 0, 0, 1, 0);
    step();
    op(2, 0, 11, 0, 64'd0, 0, 64'd0, 1, ALU_ADD, 0, 0, 0, 1, 0);
    step();
    idle();
    step(); step();
    chk("prio_addr", wb_addr, 11);
    chk("prio_data", wb_data, 64'd2);
    step(); step();

    // reset with three instructions in flight
    op(0, 0, 12, 0, 64'd40, 0, 0, 1, ALU_ADD, 1, 0, 1, 1, 0);
    step();
    op(0, 13, 0, 1, 64'd48, 64'd7, 0, 1, ALU_ADD, 0, 1, 0, 0, 0);
    step();
    op(0, 0, 14, 0, 64'd3, 0, 64'd4, 1, ALU_ADD, 0, 0, 0, 1, 0);
    step();
    idle();
    reset = 1;
    step();
    chk("rstm_wb_en", wb_en, 0);
    chk("rstm_mem_re", mem_re, 0);
    chk("rstm_mem_we", mem_we, 0);
    reset = 0;
    step();
    chk("rstm_wb_en2", wb_en, 0);
    chk("rstm_mem_we2", mem_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
